// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer.
//   state_t  : encoder FSM states
//   entry_t  : lookup result {len, pat}; pat is MSB-first, 1 = dash
//   *_UNITS  : gap and dash lengths in Morse units
package morse_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_SPACE,
        S_LGAP,
        S_WGAP
    } state_t;

    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pat;
    } entry_t;

    localparam logic [2:0] LGAP_UNITS  = 3'd3;
    localparam logic [2:0] WGAP_UNITS  = 3'd4;
    localparam logic [2:0] DASH_UNITS  = 3'd3;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/morse_rom.sv
// ASCII to Morse lookup, purely combinational.
//   char_data : ASCII code (lowercase folded to uppercase)
//   entry     : {len, pat}; pat left-aligned so the first element is bit 4
//   is_space  : char_data is the word-space marker
// Unsupported codes return len = 0.
module morse_rom
    import morse_pkg::*;
(
    input  logic [7:0] char_data,
    output entry_t     entry,
    output logic       is_space
);

    logic [7:0] folded;

    always_comb begin
        folded = char_data;
        if (char_data >= 8'h61 && char_data <= 8'h7a)
            folded = char_data - 8'h20;
        is_space = (char_data == ASCII_SPACE);
        entry    = '0;
        case (folded)
            8'h41: entry = '{3'd2, 5'b01000}; // A .-
            8'h42: entry = '{3'd4, 5'b10000}; // B -...
            8'h43: entry = '{3'd4, 5'b10100}; // C -.-.
            8'h44: entry = '{3'd3, 5'b10000}; // D -..
            8'h45: entry = '{3'd1, 5'b00000}; // E .
            8'h46: entry = '{3'd4, 5'b00100}; // F ..-.
            8'h47: entry = '{3'd3, 5'b11000}; // G --.
            8'h48: entry = '{3'd4, 5'b00000}; // H ....
            8'h49: entry = '{3'd2, 5'b00000}; // I ..
            8'h4a: entry = '{3'd4, 5'b01110}; // J .---
            8'h4b: entry = '{3'd3, 5'b10100}; // K -.-
            8'h4c: entry = '{3'd4, 5'b01000}; // L .-..
            8'h4d: entry = '{3'd2, 5'b11000}; // M --
            8'h4e: entry = '{3'd2, 5'b10000}; // N -.
            8'h4f: entry = '{3'd3, 5'b11100}; // O ---
            8'h50: entry = '{3'd4, 5'b01100}; // P .--.
            8'h51: entry = '{3'd4, 5'b11010}; // Q --.-
            8'h52: entry = '{3'd3, 5'b01000}; // R .-.
            8'h53: entry = '{3'd3, 5'b00000}; // S ...
            8'h54: entry = '{3'd1, 5'b10000}; // T -
            8'h55: entry = '{3'd3, 5'b00100}; // U ..-
            8'h56: entry = '{3'd4, 5'b00010}; // V ...-
            8'h57: entry = '{3'd3, 5'b01100}; // W .--
            8'h58: entry = '{3'd4, 5'b10010}; // X -..-
            8'h59: entry = '{3'd4, 5'b10110}; // Y -.--
            8'h5a: entry = '{3'd4, 5'b11000}; // Z --..
            8'h30: entry = '{3'd5, 5'b11111}; // 0
            8'h31: entry = '{3'd5, 5'b01111}; // 1
            8'h32: entry = '{3'd5, 5'b00111}; // 2
            8'h33: entry = '{3'd5, 5'b00011}; // 3
            8'h34: entry = '{3'd5, 5'b00001}; // 4
            8'h35: entry = '{3'd5, 5'b00000}; // 5
            8'h36: entry = '{3'd5, 5'b10000}; // 6
            8'h37: entry = '{3'd5, 5'b11000}; // 7
            8'h38: entry = '{3'd5, 5'b11100}; // 8
            8'h39: entry = '{3'd5, 5'b11110}; // 9
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/morse_encoder.sv
// Streaming Morse keyer: accepts ASCII over valid/ready, drives key_out.
//   clk, rst    : clock, synchronous active-high reset
//   char_valid  : source offers char_data
//   char_data   : ASCII character, sampled on the accepting edge
//   char_ready  : encoder idle and able to accept
//   key_out     : registered key, 1 = mark
//   busy        : character (including trailing gap) in progress
//
// state   | meaning
// S_IDLE  | waiting for a character
// S_MARK  | key on, 1 unit (dot) or 3 units (dash)
// S_SPACE | inter-element space, 1 unit
// S_LGAP  | letter gap, 3 units
// S_WGAP  | word gap, 4 units (7 total after the preceding letter gap)
module morse_encoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 2097152
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy
);

    localparam int             CW       = $clog2(UNIT_CYCLES);
    localparam logic [CW-1:0]  CYC_LAST = CW'(UNIT_CYCLES - 1);

    state_t        state, state_next;
    logic [CW-1:0] cyc_cnt;
    logic [2:0]    unit_cnt;
    logic [2:0]    elem_cnt;
    logic [4:0]    shift_reg;
    entry_t        entry;
    logic          is_space;
    logic          accept;
    logic          unit_end;
    logic          state_done;
    logic [2:0]    units_needed;

    morse_rom u_rom (
        .char_data (char_data),
        .entry     (entry),
        .is_space  (is_space)
    );

    assign char_ready = (state == S_IDLE) && !rst;
    assign busy       = (state != S_IDLE);
    assign accept     = char_valid && char_ready;

    always_comb begin
        state_next   = state;
        units_needed = 3'd1;
        case (state)
            S_MARK:  units_needed = shift_reg[4] ? DASH_UNITS : 3'd1;
            S_LGAP:  units_needed = LGAP_UNITS;
            S_WGAP:  units_needed = WGAP_UNITS;
            default: units_needed = 3'd1;
        endcase
        unit_end   = (cyc_cnt == CYC_LAST);
        state_done = unit_end && (unit_cnt == units_needed - 3'd1);

        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (entry.len != 3'd0)
                        state_next = S_MARK;
                    else if (is_space)
                        state_next = S_WGAP;
                end
            end
            S_MARK:  if (state_done) state_next = (elem_cnt > 3'd1) ? S_SPACE : S_LGAP;
            S_SPACE: if (state_done) state_next = S_MARK;
            S_LGAP:  if (state_done) state_next = S_IDLE;
            S_WGAP:  if (state_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            key_out   <= 1'b0;
            cyc_cnt   <= '0;
            unit_cnt  <= '0;
            elem_cnt  <= '0;
            shift_reg <= '0;
        end else begin
            state   <= state_next;
            // Registered from the next state so the mark starts right after the accepting edge.
            key_out <= (state_next == S_MARK);

            if (state == S_IDLE || state_next != state) begin
                cyc_cnt  <= '0;
                unit_cnt <= '0;
            end else if (unit_end) begin
                cyc_cnt  <= '0;
                unit_cnt <= unit_cnt + 3'd1;
            end else begin
                cyc_cnt  <= cyc_cnt + 1'b1;
            end

            if (state == S_IDLE && accept && entry.len != 3'd0) begin
                shift_reg <= entry.pat;
                elem_cnt  <= entry.len;
            end else if (state == S_MARK && state_done) begin
                shift_reg <= {shift_reg[3:0], 1'b0};
                elem_cnt  <= elem_cnt - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
module tb_morse_encoder;
    import morse_pkg::*;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_ready;
    logic       key_out;
    logic       busy;

    morse_encoder #(.UNIT_CYCLES(U)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .key_out    (key_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic key;
        logic bsy;
    } exp_t;

    // code holds up to five ASCII symbols, first symbol in the highest non-zero byte:
    // '.' dot, '-' dash, ' ' word gap, empty = unsupported character.
    typedef struct packed {
        logic [7:0]  ch;
        logic [39:0] code;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [7:0] c, input string s);
        vec_t v;
        v.ch   = c;
        v.code = '0;
        for (int i = 0; i < s.len(); i++)
            v.code = {v.code[31:0], s.getc(i)};
        tbl.push_back(v);
    endtask

    task automatic push_n(input logic k, input logic b, input int n);
        exp_t e;
        e.key = k;
        e.bsy = b;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // Expected per-cycle waveform starting the cycle after acceptance.
    task automatic push_code(input logic [39:0] code);
        logic [7:0] b;
        for (int i = 4; i >= 0; i--) begin
            b = code[i*8 +: 8];
            if (b == 8'h20) begin
                push_n(1'b0, 1'b1, 4 * U);
            end else if (b != 8'h00) begin
                push_n(1'b1, 1'b1, (b == 8'h2d) ? 3 * U : U);
                push_n(1'b0, 1'b1, (i == 0) ? 3 * U : U);
            end
        end
    endtask

    task automatic drain(input string name);
        exp_t e;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk({name, "_key"}, key_out, e.key);
            chk({name, "_busy"}, busy, e.bsy);
        end
    endtask

    task automatic send(input vec_t v);
        string name;
        name = $sformatf("char_%02h", v.ch);
        @(negedge clk);
        chk({name, "_ready"}, char_ready, 1'b1);
        chk({name, "_idle_key"}, key_out, 1'b0);
        char_valid = 1'b1;
        char_data  = v.ch;
        @(posedge clk);
        push_code(v.code);
        #1 char_valid = 1'b0;
        drain(name);
    endtask

    initial begin
        string sstr;
        int    idx;
        bit    started;
        bit    acc;
        exp_t  e;

        add("E", ".");
        add("A", ".-");
        add("e", ".");
        add("0", "-----");
        add("T", "-");
        add("Q", "--.-");
        add("z", "--..");
        add("9", "----.");
        add("S", "...");
        add(" ", " ");
        add("#", "");
        add("k", "-.-");

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", char_ready, 1'b0);
        chk("rst_key", key_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", char_ready, 1'b1);

        foreach (tbl[i]) send(tbl[i]);

        // Unsupported characters dropped one per cycle with valid held high
        @(negedge clk);
        char_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            char_data = (i == 0) ? 8'h23 : (i == 1) ? 8'h21 : 8'h7e;
            chk("unsup_ready", char_ready, 1'b1);
            @(negedge clk);
            chk("unsup_key", key_out, 1'b0);
            chk("unsup_busy", busy, 1'b0);
        end
        char_valid = 1'b0;

        // "E E" streamed with valid held high
        sstr    = "E E";
        idx     = 0;
        started = 1'b0;
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = sstr.getc(0);
        for (int cyc = 0; cyc < 200 && !(idx == 3 && exp_q.size() == 0); cyc++) begin
            @(negedge clk);
            if (started && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stream_key", key_out, e.key);
                chk("stream_busy", busy, e.bsy);
            end
            acc = char_ready && char_valid;
            @(posedge clk);
            if (acc) begin
                started = 1'b1;
                if (sstr.getc(idx) == 8'h20) push_n(1'b0, 1'b1, 4 * U);
                else                          push_code({32'h0, 8'h2e});
                if (idx < 2) push_n(1'b0, 1'b0, 1);
                idx++;
                #1;
                if (idx == 3) char_valid = 1'b0;
                else          char_data  = sstr.getc(idx);
            end
        end
        chk("stream_done", (idx == 3 && exp_q.size() == 0), 1'b1);
        char_valid = 1'b0;
        exp_q.delete();

        // Reset during the first dash of 'T'
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = "T";
        @(posedge clk);
        #1 char_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("t_mark", key_out, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_key", key_out, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", char_ready, 1'b0);
        rst = 1'b0;
        #1 chk("after_rst_ready", char_ready, 1'b1);
        begin
            vec_t v;
            v.ch   = "E";
            v.code = {32'h0, 8'h2e};
            send(v);
        end
        @(negedge clk);
        chk("final_ready", char_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
